// File: rtl/sys_bus_matrix.sv
// rtl/sys_bus_matrix.sv - two-master (instruction/data) to N-slave bus matrix
// Address-decoded slaves, per-slave round-robin arbitration, wait timeout.
module sys_bus_matrix #(
  parameter int                         NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*32-1:0]   SLV_BASE   = {32'h3000_0000, 32'h2000_0000,
                                                      32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0]   SLV_MASK   = {4{32'hF000_0000}},
  parameter int                         TIMEOUT    = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_req,
  input  logic [31:0]               i_addr,
  output logic [31:0]               i_rdata,
  output logic                      i_ready,
  output logic                      i_err,
  input  logic                      d_req,
  input  logic                      d_we,
  input  logic [31:0]               d_addr,
  input  logic [31:0]               d_wdata,
  input  logic [1:0]                d_size,
  output logic [31:0]               d_rdata,
  output logic                      d_ready,
  output logic                      d_err,
  output logic [NUM_SLAVES-1:0]     s_req,
  output logic [NUM_SLAVES-1:0]     s_we,
  output logic [NUM_SLAVES*32-1:0]  s_addr,
  output logic [NUM_SLAVES*32-1:0]  s_wdata,
  output logic [NUM_SLAVES*2-1:0]   s_size,
  input  logic [NUM_SLAVES*32-1:0]  s_rdata,
  input  logic [NUM_SLAVES-1:0]     s_ready,
  output logic                      busy
);

  localparam int         SW      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ARB, WAIT, RESP} state_t;

  // Returns {hit, index}; descending scan so the lowest matching slave wins.
  function automatic logic [SW:0] f_decode(input logic [31:0] a);
    logic [SW:0] res;
    res = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if ((a & SLV_MASK[k*32 +: 32]) == SLV_BASE[k*32 +: 32]) res = {1'b1, SW'(k)};
    end
    return res;
  endfunction

  state_t          r_i_state, r_d_state;
  logic [31:0]     r_i_addr, r_d_addr, r_d_wdata;
  logic [1:0]      r_d_size;
  logic            r_d_we;
  logic [SW-1:0]   r_i_sel, r_d_sel;
  logic            r_i_hit, r_d_hit;
  logic [7:0]      r_i_cnt, r_d_cnt;
  logic [NUM_SLAVES-1:0] r_last_d;

  logic [SW:0]     w_i_dec, w_d_dec;
  logic [31:0]     w_s_rdata [NUM_SLAVES];
  logic            w_i_owns, w_d_owns, w_i_arb, w_d_arb, w_same, w_tie;
  logic            w_i_grant, w_d_grant;
  logic            w_i_rdy, w_d_rdy, w_i_tmo, w_d_tmo, w_i_done, w_d_done;

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_rdata
    assign w_s_rdata[g] = s_rdata[g*32 +: 32];
  end

  assign w_i_dec  = f_decode(i_addr);
  assign w_d_dec  = f_decode(d_addr);
  assign w_i_owns = r_i_hit && (r_i_state == WAIT || r_i_state == RESP);
  assign w_d_owns = r_d_hit && (r_d_state == WAIT || r_d_state == RESP);
  assign w_i_arb  = (r_i_state == ARB);
  assign w_d_arb  = (r_d_state == ARB);
  assign w_same   = (r_i_sel == r_d_sel);
  assign w_tie    = w_i_arb && w_d_arb && w_same;

  // r_last_d[k]=1 means data won the last tie on slave k, so inst wins the next.
  assign w_d_grant = w_d_arb && !(w_i_owns && w_same) && !(w_tie && r_last_d[r_d_sel]);
  assign w_i_grant = w_i_arb && !(w_d_owns && w_same) && !(w_tie && !r_last_d[r_i_sel]);

  assign w_i_rdy  = s_ready[r_i_sel];
  assign w_d_rdy  = s_ready[r_d_sel];
  assign w_i_tmo  = (r_i_cnt == TO_LAST);
  assign w_d_tmo  = (r_d_cnt == TO_LAST);
  assign w_i_done = (r_i_state == WAIT) && (w_i_rdy || w_i_tmo);
  assign w_d_done = (r_d_state == WAIT) && (w_d_rdy || w_d_tmo);

  assign busy = (r_i_state != IDLE) || (r_d_state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i_state <= IDLE;
      r_i_addr  <= '0;
      r_i_sel   <= '0;
      r_i_hit   <= 1'b0;
      r_i_cnt   <= '0;
      i_rdata   <= '0;
      i_ready   <= 1'b0;
      i_err     <= 1'b0;
    end else begin
      case (r_i_state)
        IDLE: begin
          if (i_req) begin
            r_i_addr <= i_addr;
            r_i_sel  <= w_i_dec[SW-1:0];
            r_i_hit  <= w_i_dec[SW];
            if (w_i_dec[SW]) begin
              r_i_state <= ARB;
            end else begin
              r_i_state <= RESP;
              i_ready   <= 1'b1;
              i_err     <= 1'b1;
              i_rdata   <= '0;
            end
          end
        end
        ARB: begin
          if (w_i_grant) begin
            r_i_state <= WAIT;
            r_i_cnt   <= '0;
          end
        end
        WAIT: begin
          if (w_i_rdy) begin
            r_i_state <= RESP;
            i_ready   <= 1'b1;
            i_err     <= 1'b0;
            i_rdata   <= w_s_rdata[r_i_sel];
          end else if (w_i_tmo) begin
            r_i_state <= RESP;
            i_ready   <= 1'b1;
            i_err     <= 1'b1;
            i_rdata   <= '0;
          end else begin
            r_i_cnt <= r_i_cnt + 8'd1;
          end
        end
        default: begin
          r_i_state <= IDLE;
          i_ready   <= 1'b0;
          i_err     <= 1'b0;
          i_rdata   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d_state <= IDLE;
      r_d_addr  <= '0;
      r_d_wdata <= '0;
      r_d_size  <= '0;
      r_d_we    <= 1'b0;
      r_d_sel   <= '0;
      r_d_hit   <= 1'b0;
      r_d_cnt   <= '0;
      d_rdata   <= '0;
      d_ready   <= 1'b0;
      d_err     <= 1'b0;
    end else begin
      case (r_d_state)
        IDLE: begin
          if (d_req) begin
            r_d_addr  <= d_addr;
            r_d_wdata <= d_wdata;
            r_d_size  <= d_size;
            r_d_we    <= d_we;
            r_d_sel   <= w_d_dec[SW-1:0];
            r_d_hit   <= w_d_dec[SW];
            if (w_d_dec[SW]) begin
              r_d_state <= ARB;
            end else begin
              r_d_state <= RESP;
              d_ready   <= 1'b1;
              d_err     <= 1'b1;
              d_rdata   <= '0;
            end
          end
        end
        ARB: begin
          if (w_d_grant) begin
            r_d_state <= WAIT;
            r_d_cnt   <= '0;
          end
        end
        WAIT: begin
          if (w_d_rdy) begin
            r_d_state <= RESP;
            d_ready   <= 1'b1;
            d_err     <= 1'b0;
            d_rdata   <= r_d_we ? 32'd0 : w_s_rdata[r_d_sel];
          end else if (w_d_tmo) begin
            r_d_state <= RESP;
            d_ready   <= 1'b1;
            d_err     <= 1'b1;
            d_rdata   <= '0;
          end else begin
            r_d_cnt <= r_d_cnt + 8'd1;
          end
        end
        default: begin
          r_d_state <= IDLE;
          d_ready   <= 1'b0;
          d_err     <= 1'b0;
          d_rdata   <= '0;
        end
      endcase
    end
  end

  // Slave-side registers: loaded on grant, cleared when the owner leaves WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_req    <= '0;
      s_we     <= '0;
      s_addr   <= '0;
      s_wdata  <= '0;
      s_size   <= '0;
      r_last_d <= '0;
    end else begin
      if (w_tie) r_last_d[r_d_sel] <= w_d_grant;
      for (int k = 0; k < NUM_SLAVES; k++) begin
        if (w_i_grant && r_i_sel == SW'(k)) begin
          s_req[k]            <= 1'b1;
          s_we[k]             <= 1'b0;
          s_addr[k*32 +: 32]  <= r_i_addr;
          s_wdata[k*32 +: 32] <= '0;
          s_size[k*2 +: 2]    <= 2'b10;
        end else if (w_d_grant && r_d_sel == SW'(k)) begin
          s_req[k]            <= 1'b1;
          s_we[k]             <= r_d_we;
          s_addr[k*32 +: 32]  <= r_d_addr;
          s_wdata[k*32 +: 32] <= r_d_wdata;
          s_size[k*2 +: 2]    <= r_d_size;
        end else if ((w_i_done && r_i_sel == SW'(k)) || (w_d_done && r_d_sel == SW'(k))) begin
          s_req[k]            <= 1'b0;
          s_we[k]             <= 1'b0;
          s_addr[k*32 +: 32]  <= '0;
          s_wdata[k*32 +: 32] <= '0;
          s_size[k*2 +: 2]    <= '0;
        end
      end
    end
  end

endmodule
